segre_m_ext_pipeline: RTL and testbench
=======================================

SEGRE_M_EXT_PIPELINE -- requirements
Module: segre_m_ext_pipeline

Interface
REQ-001 Parameters SHALL be: none; all widths SHALL come from segre_pkg (WORD_SIZE=32, REG_SIZE=5).
REQ-002 clk_i  in  1  single clock; all state updates on rising edge.
REQ-003 rst_i  in  1  reset, synchronous, active-high.
REQ-004 valid_m1_i  in  1  M-ext op presented by decode this cycle.
REQ-005 m1_opcode_i  in  m_ext_opcode_e  operation select.
REQ-006 m1_rf_waddr_i  in  REG_SIZE  destination register.
REQ-007 m1_rf_src_a_i / m1_rf_src_b_i  in  WORD_SIZE  operands, already bypassed.
REQ-008 block_m_i  in  1  controller stall; hold all stages.
REQ-009 stage_valid_o  out  5  valid bit of M1..M5 (bit0=M1), for hazard detection.
REQ-010 stage_waddr_o  out  5*REG_SIZE  destination of M1..M5, packed, M1 in LSBs.
REQ-011 m5_valid_o  out  1  M5 holds a completed op.
REQ-012 m5_rf_we_o  out  1  register-file write enable from M5.
REQ-013 m5_rf_waddr_o  out  REG_SIZE  write address.
REQ-014 m5_rd_data_o  out  WORD_SIZE  result; also the M5 bypass source.
REQ-015 unsupported_o  out  1  M5 holds an opcode this block does not execute.
REQ-016 busy_o  out  1  OR of stage_valid_o.

Function
REQ-017 The block SHALL be five register stages M1..M5; an op sampled with valid_m1_i=1 and block_m_i=0 in cycle N SHALL appear on the M5 outputs in cycle N+5.
REQ-018 Throughput SHALL be one op per cycle with no internal stalls.
REQ-019 block_m_i=1 SHALL hold every stage register, ignore the inputs, and keep all outputs stable; no op is lost or duplicated.
REQ-020 With block_m_i=0 and valid_m1_i=0, a bubble (valid=0) SHALL enter M1.
REQ-021 M1 SHALL register the operands sign- or zero-extended to 33 bits: MUL/MULH signed-signed, MULHSU signed-unsigned, MULHU unsigned-unsigned.
REQ-022 M2 SHALL register four partial products from 17-bit signed high and 16-bit unsigned low halves.
REQ-023 M3 SHALL register the summed middle terms.
REQ-024 M4 SHALL register the full 64-bit product.
REQ-025 M5 SHALL register the selected 32-bit result: MUL = product[31:0]; MULH, MULHSU and MULHU = product[63:32].
REQ-026 DIV, DIVU, REM and REMU opcodes SHALL flow through with m5_rd_data_o=0, m5_rf_we_o=0 and unsupported_o=1.
REQ-027 m5_rf_we_o SHALL equal m5_valid_o AND NOT unsupported_o.
REQ-028 Invalid stages SHALL drive their waddr field to 0.
REQ-029 Data and opcode fields SHALL NOT be interpreted when the stage valid bit is 0.

Reset
REQ-030 rst_i=1 at a clock edge SHALL clear all five valid bits, regardless of block_m_i; reset has priority.
REQ-031 During reset, all outputs SHALL be 0 in the following cycle, including busy_o, stage_waddr_o and m5_rd_data_o.
REQ-032 Ops in flight at reset SHALL be discarded and SHALL NOT write back.

Structure
REQ-033 m_ext_opcode_e and the stage count constant (M_EXT_STAGES=5) SHALL live in segre_pkg.
REQ-034 The partial-product and summation datapath SHALL be one sub-module, segre_mul_datapath; valid, waddr and opcode tracking stays in the top module.

Verification
REQ-035 MUL 7 x 0xFFFFFFFD issued in cycle N -> cycle N+5: m5_rd_data_o=0xFFFFFFEB, m5_rf_we_o=1.
REQ-036 MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
REQ-037 Five back-to-back MULs (x1..x5) issued in cycles N..N+4 -> results in cycles N+5..N+9, one per cycle, correct waddr each, and stage_valid_o=5'b11111 in cycle N+5.
REQ-038 block_m_i high for 3 cycles while M1..M3 are full -> outputs frozen for 3 cycles, then results delayed by exactly 3 cycles, none duplicated.
REQ-039 rst_i pulsed for 1 cycle with 4 ops in flight -> next cycle stage_valid_o=0 and busy_o=0; no m5_rf_we_o pulse afterward.
REQ-040 DIVU issued in cycle N -> cycle N+5: m5_valid_o=1, unsupported_o=1, m5_rf_we_o=0, m5_rd_data_o=0.

Source files
------------

// File: rtl/segre_pkg.sv
// Shared widths, opcode encoding and opcode decode helpers for the M-extension pipeline.
package segre_pkg;

    localparam int WORD_SIZE    = 32;
    localparam int REG_SIZE     = 5;
    localparam int M_EXT_STAGES = 5;

    typedef enum logic [2:0] {
        M_MUL    = 3'd0,
        M_MULH   = 3'd1,
        M_MULHSU = 3'd2,
        M_MULHU  = 3'd3,
        M_DIV    = 3'd4,
        M_DIVU   = 3'd5,
        M_REM    = 3'd6,
        M_REMU   = 3'd7
    } m_ext_opcode_e;

    // True for the opcodes this pipeline actually executes.
    function automatic logic is_mul_op(input m_ext_opcode_e op);
        return (op == M_MUL) || (op == M_MULH) || (op == M_MULHSU) || (op == M_MULHU);
    endfunction

    // Operand A is treated as signed for MUL, MULH and MULHSU.
    function automatic logic op_signed_a(input m_ext_opcode_e op);
        return (op == M_MUL) || (op == M_MULH) || (op == M_MULHSU);
    endfunction

    // Operand B is treated as signed only for MUL and MULH.
    function automatic logic op_signed_b(input m_ext_opcode_e op);
        return (op == M_MUL) || (op == M_MULH);
    endfunction

endpackage

// File: rtl/segre_m_ext_pipeline_if.sv
// Decode-to-M-pipeline bundle: issue signals toward the pipeline, status and writeback back out.
// Handshake: an op is accepted on a rising edge when valid_m1_i=1 and block_m_i=0;
// there is no ready, block_m_i freezes the whole pipeline including its outputs.
interface segre_m_ext_pipeline_if;
    import segre_pkg::*;

    logic                        valid_m1_i;
    m_ext_opcode_e               m1_opcode_i;
    logic [REG_SIZE-1:0]         m1_rf_waddr_i;
    logic [WORD_SIZE-1:0]        m1_rf_src_a_i;
    logic [WORD_SIZE-1:0]        m1_rf_src_b_i;
    logic                        block_m_i;

    logic [M_EXT_STAGES-1:0]          stage_valid_o;
    logic [M_EXT_STAGES*REG_SIZE-1:0] stage_waddr_o;
    logic                             m5_valid_o;
    logic                             m5_rf_we_o;
    logic [REG_SIZE-1:0]              m5_rf_waddr_o;
    logic [WORD_SIZE-1:0]             m5_rd_data_o;
    logic                             unsupported_o;
    logic                             busy_o;

    modport master (
        output valid_m1_i, m1_opcode_i, m1_rf_waddr_i, m1_rf_src_a_i, m1_rf_src_b_i, block_m_i,
        input  stage_valid_o, stage_waddr_o, m5_valid_o, m5_rf_we_o, m5_rf_waddr_o,
               m5_rd_data_o, unsupported_o, busy_o
    );

    modport slave (
        input  valid_m1_i, m1_opcode_i, m1_rf_waddr_i, m1_rf_src_a_i, m1_rf_src_b_i, block_m_i,
        output stage_valid_o, stage_waddr_o, m5_valid_o, m5_rf_we_o, m5_rf_waddr_o,
               m5_rd_data_o, unsupported_o, busy_o
    );

endinterface

// File: rtl/segre_mul_datapath.sv
// Four-register 33x33 multiply datapath (M1..M4): extend, partial products, middle sum, full product.
// Data registers carry no reset; their contents only matter when the matching valid bit is set.
module segre_mul_datapath
    import segre_pkg::*;
(
    input  logic                   clk_i,
    input  logic                   en_i,
    input  logic                   signed_a_i,
    input  logic                   signed_b_i,
    input  logic [WORD_SIZE-1:0]   src_a_i,
    input  logic [WORD_SIZE-1:0]   src_b_i,
    output logic [2*WORD_SIZE-1:0] product_o
);

    logic [WORD_SIZE:0]   a_m1, b_m1;
    logic signed [16:0]   a_hi, a_lo, b_hi, b_lo;
    logic signed [33:0]   pp_hh_m2, pp_hl_m2, pp_lh_m2, pp_ll_m2;
    logic [33:0]          hh_m3, ll_m3;
    logic [34:0]          mid_m3;
    logic [65:0]          full_sum;
    logic [2*WORD_SIZE-1:0] product_m4;

    // Split the 33-bit operands into a signed 17-bit high half and a zero-extended low half.
    always_comb begin
        a_hi = $signed(a_m1[32:16]);
        b_hi = $signed(b_m1[32:16]);
        a_lo = $signed({1'b0, a_m1[15:0]});
        b_lo = $signed({1'b0, b_m1[15:0]});
        full_sum = {hh_m3, 32'b0}
                 + {{15{mid_m3[34]}}, mid_m3, 16'b0}
                 + {{32{ll_m3[33]}}, ll_m3};
    end

    // Stage registers advance together whenever the pipeline is not blocked.
    always_ff @(posedge clk_i) begin
        if (en_i) begin
            a_m1       <= {signed_a_i & src_a_i[WORD_SIZE-1], src_a_i};
            b_m1       <= {signed_b_i & src_b_i[WORD_SIZE-1], src_b_i};
            pp_hh_m2   <= a_hi * b_hi;
            pp_hl_m2   <= a_hi * b_lo;
            pp_lh_m2   <= a_lo * b_hi;
            pp_ll_m2   <= a_lo * b_lo;
            hh_m3      <= pp_hh_m2;
            ll_m3      <= pp_ll_m2;
            mid_m3     <= {pp_hl_m2[33], pp_hl_m2} + {pp_lh_m2[33], pp_lh_m2};
            product_m4 <= full_sum[63:0];
        end
    end

    assign product_o = product_m4;

endmodule

// File: rtl/segre_m_ext_pipeline.sv
// Five-stage M-extension pipeline: tracks valid/waddr/opcode per stage and selects the M5 result.
module segre_m_ext_pipeline
    import segre_pkg::*;
(
    input  logic                    clk_i,
    input  logic                    rst_i,
    segre_m_ext_pipeline_if.slave   bus
);

    logic [M_EXT_STAGES-1:0]                valid_q;
    logic [M_EXT_STAGES-1:0][REG_SIZE-1:0]  waddr_q;
    m_ext_opcode_e                          op_q [M_EXT_STAGES];
    logic [WORD_SIZE-1:0]                   rd_data_q;
    logic [WORD_SIZE-1:0]                   rd_data_next;
    logic [2*WORD_SIZE-1:0]                 product;
    logic                                   advance;

    assign advance = !bus.block_m_i;

    segre_mul_datapath u_datapath (
        .clk_i      (clk_i),
        .en_i       (advance),
        .signed_a_i (op_signed_a(bus.m1_opcode_i)),
        .signed_b_i (op_signed_b(bus.m1_opcode_i)),
        .src_a_i    (bus.m1_rf_src_a_i),
        .src_b_i    (bus.m1_rf_src_b_i),
        .product_o  (product)
    );

    // Result selection for the op leaving M4; unsupported or empty slots produce zero.
    always_comb begin
        rd_data_next = '0;
        if (valid_q[3] && is_mul_op(op_q[3])) begin
            if (op_q[3] == M_MUL) rd_data_next = product[WORD_SIZE-1:0];
            else                  rd_data_next = product[2*WORD_SIZE-1:WORD_SIZE];
        end
    end

    // Control shift register; reset wins over block and drops every in-flight op.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q   <= '0;
            rd_data_q <= '0;
        end else if (advance) begin
            valid_q   <= {valid_q[M_EXT_STAGES-2:0], bus.valid_m1_i};
            waddr_q   <= {waddr_q[M_EXT_STAGES-2:0], bus.m1_rf_waddr_i};
            rd_data_q <= rd_data_next;
            op_q[0]   <= bus.m1_opcode_i;
            for (int i = 1; i < M_EXT_STAGES; i++) begin
                op_q[i] <= op_q[i-1];
            end
        end
    end

    // Per-stage destination, forced to zero for empty stages.
    always_comb begin
        bus.stage_waddr_o = '0;
        for (int i = 0; i < M_EXT_STAGES; i++) begin
            if (valid_q[i]) bus.stage_waddr_o[i*REG_SIZE +: REG_SIZE] = waddr_q[i];
        end
    end

    assign bus.stage_valid_o = valid_q;
    assign bus.busy_o        = |valid_q;
    assign bus.m5_valid_o    = valid_q[4];
    assign bus.unsupported_o = valid_q[4] && !is_mul_op(op_q[4]);
    assign bus.m5_rf_we_o    = valid_q[4] && is_mul_op(op_q[4]);
    assign bus.m5_rf_waddr_o = valid_q[4] ? waddr_q[4] : '0;
    assign bus.m5_rd_data_o  = rd_data_q;

endmodule

// File: tb/tb_segre_m_ext_pipeline.sv
// Randomized plus directed bench for segre_m_ext_pipeline against an issue-time result model.
module tb_segre_m_ext_pipeline;
    import segre_pkg::*;

    typedef struct {
        bit          v;
        logic [4:0]  wa;
        logic [31:0] res;
        bit          unsup;
    } slot_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    slot_t mdl [5];

    segre_m_ext_pipeline_if bus ();

    segre_m_ext_pipeline dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout exp completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Architectural result computed straight from the RISC-V M definitions.
    function automatic logic [31:0] ref_result(input m_ext_opcode_e op, input logic [31:0] a,
                                               input logic [31:0] b);
        logic [63:0] sa, za, sb, zb, p;
        sa = {{32{a[31]}}, a};
        za = {32'b0, a};
        sb = {{32{b[31]}}, b};
        zb = {32'b0, b};
        case (op)
            M_MUL:    begin p = sa * sb; return p[31:0];  end
            M_MULH:   begin p = sa * sb; return p[63:32]; end
            M_MULHSU: begin p = sa * zb; return p[63:32]; end
            M_MULHU:  begin p = za * zb; return p[63:32]; end
            default:  return 32'b0;
        endcase
    endfunction

    task automatic compare_outputs();
        logic [4:0]  exp_valid;
        logic [24:0] exp_waddr;
        bit          v4;
        exp_valid = '0;
        exp_waddr = '0;
        for (int i = 0; i < 5; i++) begin
            exp_valid[i] = mdl[i].v;
            if (mdl[i].v) exp_waddr[i*5 +: 5] = mdl[i].wa;
        end
        v4 = mdl[4].v;
        check("stage_valid", bus.stage_valid_o, exp_valid);
        check("stage_waddr", bus.stage_waddr_o, exp_waddr);
        check("busy", bus.busy_o, |exp_valid);
        check("m5_valid", bus.m5_valid_o, v4);
        check("m5_we", bus.m5_rf_we_o, v4 && !mdl[4].unsup);
        check("unsupported", bus.unsupported_o, v4 && mdl[4].unsup);
        check("m5_waddr", bus.m5_rf_waddr_o, v4 ? mdl[4].wa : 5'd0);
        check("m5_rd_data", bus.m5_rd_data_o, (v4 && !mdl[4].unsup) ? mdl[4].res : 32'd0);
    endtask

    // Driver: present inputs, let one edge pass, update the model, then compare.
    task automatic drive_cycle(input bit v, input m_ext_opcode_e op, input logic [4:0] wa,
                               input logic [31:0] a, input logic [31:0] b,
                               input bit blk, input bit rs);
        bus.valid_m1_i    = v;
        bus.m1_opcode_i   = op;
        bus.m1_rf_waddr_i = wa;
        bus.m1_rf_src_a_i = a;
        bus.m1_rf_src_b_i = b;
        bus.block_m_i     = blk;
        rst               = rs;
        @(posedge clk);
        if (rs) begin
            for (int i = 0; i < 5; i++) mdl[i].v = 1'b0;
        end else if (!blk) begin
            for (int i = 4; i > 0; i--) mdl[i] = mdl[i-1];
            mdl[0].v     = v;
            mdl[0].wa    = wa;
            mdl[0].unsup = !(op inside {M_MUL, M_MULH, M_MULHSU, M_MULHU});
            mdl[0].res   = ref_result(op, a, b);
        end
        #1;
        compare_outputs();
    endtask

    task automatic bubble();
        drive_cycle(1'b0, m_ext_opcode_e'($urandom_range(0, 7)), 5'($urandom), $urandom,
                    $urandom, 1'b0, 1'b0);
    endtask

    task automatic run_single(input string tag, input m_ext_opcode_e op, input logic [31:0] a,
                              input logic [31:0] b, input logic [31:0] exp_rd,
                              input bit exp_we);
        drive_cycle(1'b1, op, 5'd9, a, b, 1'b0, 1'b0);
        repeat (4) bubble();
        check({tag, "_rd"}, bus.m5_rd_data_o, exp_rd);
        check({tag, "_we"}, bus.m5_rf_we_o, exp_we);
        check({tag, "_valid"}, bus.m5_valid_o, 1'b1);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        for (int i = 0; i < 5; i++) mdl[i] = '{v: 1'b0, wa: 5'd0, res: 32'd0, unsup: 1'b0};

        // Reset, including with block asserted
        drive_cycle(1'b1, M_MUL, 5'd1, 32'd1, 32'd1, 1'b0, 1'b1);
        drive_cycle(1'b1, M_MUL, 5'd1, 32'd1, 32'd1, 1'b1, 1'b1);
        check("reset_busy", bus.busy_o, 1'b0);
        check("reset_rd", bus.m5_rd_data_o, 32'd0);

        // Single-op corner values
        run_single("mul_7xm3", M_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b1);
        run_single("mulh_min", M_MULH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b1);
        run_single("mulhu_max", M_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1);
        run_single("mulhsu_m1", M_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        run_single("divu", M_DIVU, 32'd100, 32'd7, 32'd0, 1'b0);
        check("divu_unsup", bus.unsupported_o, 1'b1);

        // Back-to-back MULs to x1..x5
        for (int i = 1; i <= 5; i++) drive_cycle(1'b1, M_MUL, 5'(i), 32'(i), 32'(i + 10), 1'b0, 1'b0);
        check("b2b_full", bus.stage_valid_o, 5'b11111);
        check("b2b_first_waddr", bus.m5_rf_waddr_o, 5'd1);
        repeat (5) bubble();

        // Block for three cycles with M1..M3 full; inputs during block must be ignored
        for (int i = 0; i < 3; i++) drive_cycle(1'b1, M_MULH, 5'(20 + i), $urandom, $urandom, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1'b1, M_MUL, 5'd31, $urandom, $urandom, 1'b1, 1'b0);
            check("block_frozen", bus.stage_valid_o, 5'b00111);
        end
        repeat (6) bubble();

        // Reset with four ops in flight
        for (int i = 0; i < 4; i++) drive_cycle(1'b1, M_MUL, 5'(i + 1), $urandom, $urandom, 1'b0, 1'b0);
        drive_cycle(1'b0, M_MUL, 5'd0, 32'd0, 32'd0, 1'b0, 1'b1);
        check("rst_flight_valid", bus.stage_valid_o, 5'b00000);
        check("rst_flight_busy", bus.busy_o, 1'b0);
        repeat (6) bubble();

        // Randomized traffic with blocks and rare resets
        for (int n = 0; n < 600; n++) begin
            drive_cycle($urandom_range(0, 3) != 0, m_ext_opcode_e'($urandom_range(0, 7)),
                        5'($urandom), pick_operand(), pick_operand(),
                        $urandom_range(0, 4) == 0, $urandom_range(0, 99) == 0);
        end
        repeat (6) bubble();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
